rv32_bus_fabric: RTL and testbench
==================================

# rv32_bus_fabric

Parametrised address-decode and handshake fabric between the picorv32 native memory port and up to 8 memory-mapped slaves (BRAM, seven-segment register, future peripherals). It replaces the fixed two-target decode in the SoC top level. It adds per-slave base/mask windows and registered read data. Unmapped accesses and slaves that fail to answer within a timeout are terminated with an error response, so the CPU never hangs.

## Interface
- N_SLAVES, 2: number of slave channels, 1..8.
- SLAVE_BASE, {32'h0000_1000, 32'h0000_0000}: packed N_SLAVES×32; slice i is the base of slave i.
- SLAVE_MASK, {32'hFFFF_F000, 32'hFFFF_F000}: packed N_SLAVES×32; slave i hits when (cpu_addr & mask_i) == base_i.
- TIMEOUT, 64: maximum cycles a slave sees s_valid before forced termination; 0 disables the timeout.
- ERR_DATA, 32'hDEAD_BEEF: cpu_rdata returned on an error response.
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_valid  in  1  picorv32 mem_valid; held high until cpu_ready.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_addr  in  32  picorv32 mem_addr; stable while cpu_valid is high.
- cpu_rdata  out  32  registered read data; valid while cpu_ready is high.
- s_valid  out  N_SLAVES  one-hot request to the selected slave.
- s_ready  in  N_SLAVES  per-slave completion.
- s_rdata  in  32×N_SLAVES  packed slave read data; slice i belongs to slave i.
- err_clear  in  1  clears bus_err and err_count.
- bus_err  out  1  sticky error flag.
- err_addr  out  32  cpu_addr of the most recent error.
- err_count  out  8  saturating error counter.

## Operation
- wdata and wstrb are broadcast outside the fabric. A slave acts only while its s_valid bit is high, so reads and writes follow the same protocol.
- Decode: the lowest-index slave whose window matches wins. No match means the access is unmapped.
- FSM states:
  - IDLE: if cpu_valid and the address is mapped, latch the slave index into sel, clear the timeout counter, go to ACTIVE. If cpu_valid and unmapped, load ERR_DATA into cpu_rdata, log an error, go to RESP. Otherwise stay in IDLE.
  - ACTIVE: s_valid[sel] is high.
    - If s_ready[sel] is high, register s_rdata slice sel into cpu_rdata and go to RESP.
    - Otherwise, if TIMEOUT != 0 and the counter equals TIMEOUT-1, load ERR_DATA, log an error, go to RESP.
    - Otherwise increment the counter.
    - Ready on the final allowed cycle wins over the timeout.
  - RESP: cpu_ready=1 and s_valid=0. Always return to IDLE. A new request can be accepted in the following IDLE cycle.
- s_ready bits of unselected slaves are ignored.
- Logging an error does the following: bus_err<=1, err_addr<=cpu_addr, err_count increments and saturates at 255.
- err_clear zeroes bus_err and err_count; err_addr is kept. If err_clear and a new error occur in the same cycle, the result is bus_err=1 and err_count=1.
- The timeout counter is $clog2(TIMEOUT+1) bits wide.
- Reset values: state=IDLE, cpu_ready=0, cpu_rdata=0, s_valid=0, bus_err=0, err_addr=0, err_count=0, sel=0.
- Reset mid-transaction: abort immediately. s_valid drops in the cycle after reset is sampled, and no cpu_ready is issued.

## Timing
- Cycle 0 is the first edge at which cpu_valid is sampled in IDLE.
- Mapped access: s_valid[sel] is high from cycle 1. If s_ready is sampled at cycle k (k ≥ 1), cpu_ready is high in cycle k+1. Minimum latency is 2 cycles (cpu_valid to cpu_ready).
- Unmapped access: cpu_ready is high in cycle 1.
- Timeout: the slave sees exactly TIMEOUT cycles of s_valid (cycles 1..TIMEOUT). cpu_ready is high in cycle TIMEOUT+1.
- Back-to-back: the minimum period between cpu_ready pulses is 3 cycles for mapped accesses and 2 for unmapped.
- All outputs are registered, so there is no combinational path from any input to cpu_ready or s_valid.

## Test plan
- Defaults, read 0x0000_0004. Slave 0 returns 0x1234_5678 with ready in the same cycle as s_valid. Expected: s_valid=2'b01 in cycle 1; cpu_ready and cpu_rdata=0x1234_5678 in cycle 2; bus_err stays 0.
- Write to 0x0000_1000 with wstrb=4'hF. Slave 1 raises ready after 3 cycles of s_valid. Expected: s_valid=2'b10 in cycles 1..3; a single cpu_ready in cycle 4.
- Access to unmapped 0x8000_0000. Expected: cpu_ready in cycle 1; cpu_rdata=0xDEAD_BEEF; bus_err=1; err_addr=0x8000_0000; err_count=1; no s_valid bit ever rises.
- TIMEOUT=4, slave 0 never ready. Expected: s_valid high in cycles 1..4; cpu_ready with 0xDEAD_BEEF in cycle 5; err_count increments. Repeat with ready in cycle 4: expect normal data and no error.
- Provoke 300 unmapped errors. Expected: err_count stays at 255. Then assert err_clear in the same cycle as another error is logged: expect err_count=1 and bus_err=1.
- Assert reset during ACTIVE at cycle 2. Expected: s_valid=0 from cycle 3, no cpu_ready, all outputs at their reset values. A subsequent access completes normally.

Source files
------------

// File: rtl/rv32_bus_fabric.sv
// Address-decode and handshake fabric: picorv32 native port to N memory-mapped slaves.
// Latency: mapped access >= 2 cycles valid-to-ready, unmapped 1 cycle, timeout TIMEOUT+1 cycles.
// Backpressure: the CPU is held until the slave answers, the timeout expires or decode fails.
module rv32_bus_fabric #(
    parameter int                      N_SLAVES   = 2,
    parameter logic [N_SLAVES*32-1:0]  SLAVE_BASE = {32'h0000_1000, 32'h0000_0000},
    parameter logic [N_SLAVES*32-1:0]  SLAVE_MASK = {32'hFFFF_F000, 32'hFFFF_F000},
    parameter int                      TIMEOUT    = 64,
    parameter logic [31:0]             ERR_DATA   = 32'hDEAD_BEEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cpu_valid,
    output logic                     cpu_ready,
    input  logic [31:0]              cpu_addr,
    output logic [31:0]              cpu_rdata,
    output logic [N_SLAVES-1:0]      s_valid,
    input  logic [N_SLAVES-1:0]      s_ready,
    input  logic [N_SLAVES*32-1:0]   s_rdata,
    input  logic                     err_clear,
    output logic                     bus_err,
    output logic [31:0]              err_addr,
    output logic [7:0]               err_count
);

    // Index and counter widths never collapse to zero bits for the degenerate
    // N_SLAVES=1 / TIMEOUT=0 configurations.
    localparam int SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  cpu_ready_q, cpu_ready_d;
    logic [31:0]           cpu_rdata_q, cpu_rdata_d;
    logic [N_SLAVES-1:0]   s_valid_q, s_valid_d;
    logic                  bus_err_q, bus_err_d;
    logic [31:0]           err_addr_q, err_addr_d;
    logic [7:0]            err_count_q, err_count_d;

    logic                  hit;
    logic [SEL_W-1:0]      hit_idx;
    logic                  sel_ready;
    logic [31:0]           sel_rdata;
    logic                  log_err;

    // Window decode: the lowest-index matching slave wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (!hit && ((cpu_addr & SLAVE_MASK[i*32 +: 32]) == SLAVE_BASE[i*32 +: 32])) begin
                hit     = 1'b1;
                hit_idx = SEL_W'(i);
            end
        end
    end

    // Pick out the selected slave's ready and data; other slaves are ignored.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_ready = s_ready[i];
                sel_rdata = s_rdata[i*32 +: 32];
            end
        end
    end

    // Transaction FSM: next state plus next values of all registered outputs.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        cpu_ready_d = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        s_valid_d   = '0;
        log_err     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cpu_valid) begin
                    if (hit) begin
                        sel_d   = hit_idx;
                        cnt_d   = '0;
                        state_d = ST_ACTIVE;
                        for (int i = 0; i < N_SLAVES; i++) begin
                            s_valid_d[i] = (hit_idx == SEL_W'(i));
                        end
                    end else begin
                        cpu_rdata_d = ERR_DATA;
                        cpu_ready_d = 1'b1;
                        log_err     = 1'b1;
                        state_d     = ST_RESP;
                    end
                end
            end
            ST_ACTIVE: begin
                // Ready on the last allowed cycle takes priority over the timeout.
                if (sel_ready) begin
                    cpu_rdata_d = sel_rdata;
                    cpu_ready_d = 1'b1;
                    state_d     = ST_RESP;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1))) begin
                    cpu_rdata_d = ERR_DATA;
                    cpu_ready_d = 1'b1;
                    log_err     = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    s_valid_d = s_valid_q;
                    if (TIMEOUT != 0) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Error log: clear first, so a same-cycle error leaves bus_err=1, count=1.
    always_comb begin
        bus_err_d   = bus_err_q;
        err_addr_d  = err_addr_q;
        err_count_d = err_count_q;
        if (err_clear) begin
            bus_err_d   = 1'b0;
            err_count_d = 8'd0;
        end
        if (log_err) begin
            bus_err_d   = 1'b1;
            err_addr_d  = cpu_addr;
            err_count_d = (err_count_d == 8'hFF) ? 8'hFF : err_count_d + 8'd1;
        end
    end

    // State and output registers with synchronous reset; reset aborts any transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            cnt_q       <= '0;
            cpu_ready_q <= 1'b0;
            cpu_rdata_q <= '0;
            s_valid_q   <= '0;
            bus_err_q   <= 1'b0;
            err_addr_q  <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            cpu_ready_q <= cpu_ready_d;
            cpu_rdata_q <= cpu_rdata_d;
            s_valid_q   <= s_valid_d;
            bus_err_q   <= bus_err_d;
            err_addr_q  <= err_addr_d;
            err_count_q <= err_count_d;
        end
    end

    assign cpu_ready = cpu_ready_q;
    assign cpu_rdata = cpu_rdata_q;
    assign s_valid   = s_valid_q;
    assign bus_err   = bus_err_q;
    assign err_addr  = err_addr_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_rv32_bus_fabric.sv
// Bench for rv32_bus_fabric: directed test-plan steps followed by randomized accesses.
// Expected behaviour comes from a transaction-level model (address ranges, cycle counts).
// Slaves are emulated per access with a chosen ready latency; 0 means never ready.
module tb_rv32_bus_fabric;

    localparam int          NS   = 2;
    localparam int          TO   = 4;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
    localparam logic [31:0] BASE [NS] = '{32'h0000_0000, 32'h0000_1000};
    localparam logic [31:0] MASK [NS] = '{32'hFFFF_F000, 32'hFFFF_F000};

    logic              clk;
    logic              reset;
    logic              cpu_valid;
    logic              cpu_ready;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_rdata;
    logic [NS-1:0]     s_valid;
    logic [NS-1:0]     s_ready;
    logic [NS*32-1:0]  s_rdata;
    logic              err_clear;
    logic              bus_err;
    logic [31:0]       err_addr;
    logic [7:0]        err_count;

    int tests = 0;
    int fails = 0;

    // Reference error-log state.
    logic        m_err;
    logic [31:0] m_addr;
    int          m_cnt;

    rv32_bus_fabric #(
        .N_SLAVES   (NS),
        .SLAVE_BASE ({BASE[1], BASE[0]}),
        .SLAVE_MASK ({MASK[1], MASK[0]}),
        .TIMEOUT    (TO),
        .ERR_DATA   (ERRD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_valid (cpu_valid),
        .cpu_ready (cpu_ready),
        .cpu_addr  (cpu_addr),
        .cpu_rdata (cpu_rdata),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_rdata   (s_rdata),
        .err_clear (err_clear),
        .bus_err   (bus_err),
        .err_addr  (err_addr),
        .err_count (err_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Address falls inside slave i's aligned window; first listed slave wins.
    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < NS; i++) begin
            if (a >= BASE[i] && a <= (BASE[i] | ~MASK[i])) return i;
        end
        return -1;
    endfunction

    function automatic void log_err(input logic [31:0] a);
        m_err  = 1'b1;
        m_addr = a;
        if (m_cnt < 255) m_cnt++;
    endfunction

    // One CPU access. Starts one cycle after the previous response (the IDLE cycle).
    task automatic txn(input logic [31:0] addr, input int lat, input logic [31:0] data,
                       input bit clr, input string tag);
        int          idx;
        int          rdy_cyc;
        logic [1:0]  onehot;
        logic [31:0] exp_rd;
        @(negedge clk);
        check({tag, ":idle_ready"}, cpu_ready, 32'd0);
        check({tag, ":idle_svalid"}, s_valid, 32'd0);
        idx       = decode(addr);
        cpu_valid = 1'b1;
        cpu_addr  = addr;
        err_clear = clr;
        s_ready   = NS'($urandom);
        s_rdata   = {$urandom, $urandom};
        if (clr) begin
            m_err = 1'b0;
            m_cnt = 0;
        end
        onehot = '0;
        if (idx < 0) begin
            rdy_cyc = 1;
            exp_rd  = ERRD;
            log_err(addr);
        end else begin
            onehot[idx] = 1'b1;
            if (lat >= 1 && lat <= TO) begin
                rdy_cyc = lat + 1;
                exp_rd  = data;
            end else begin
                rdy_cyc = TO + 1;
                exp_rd  = ERRD;
                log_err(addr);
            end
        end
        for (int c = 1; c <= rdy_cyc; c++) begin
            @(negedge clk);
            check({tag, ":s_valid"}, s_valid, (c < rdy_cyc) ? 32'(onehot) : 32'd0);
            check({tag, ":cpu_ready"}, cpu_ready, (c == rdy_cyc) ? 32'd1 : 32'd0);
            if (c == 1) err_clear = 1'b0;
            if (c == rdy_cyc) begin
                check({tag, ":rdata"}, cpu_rdata, exp_rd);
                check({tag, ":bus_err"}, bus_err, 32'(m_err));
                check({tag, ":err_count"}, err_count, 32'(m_cnt));
                check({tag, ":err_addr"}, err_addr, m_addr);
                cpu_valid = 1'b0;
            end
            s_ready = NS'($urandom);
            s_rdata = {$urandom, $urandom};
            if (idx >= 0) begin
                s_ready[idx] = (c == lat);
                if (c == lat) s_rdata[idx*32 +: 32] = data;
            end
        end
    endtask

    initial begin
        logic [31:0] a;
        int          k;
        reset     = 1'b1;
        cpu_valid = 1'b0;
        cpu_addr  = '0;
        s_ready   = '0;
        s_rdata   = '0;
        err_clear = 1'b0;
        m_err     = 1'b0;
        m_addr    = '0;
        m_cnt     = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst:cpu_ready", cpu_ready, 32'd0);
        check("rst:cpu_rdata", cpu_rdata, 32'd0);
        check("rst:s_valid", s_valid, 32'd0);
        check("rst:bus_err", bus_err, 32'd0);
        check("rst:err_addr", err_addr, 32'd0);
        check("rst:err_count", err_count, 32'd0);

        // Zero-wait read from slave 0, 3-cycle slave 1, unmapped, timeout, last-cycle ready.
        txn(32'h0000_0004, 1, 32'h1234_5678, 1'b0, "read_s0");
        txn(32'h0000_1000, 3, 32'hCAFE_0001, 1'b0, "write_s1");
        txn(32'h8000_0000, 1, 32'h0, 1'b0, "unmapped");
        txn(32'h0000_0010, 0, 32'h0, 1'b0, "timeout");
        txn(32'h0000_0014, TO, 32'h5A5A_A5A5, 1'b0, "last_cycle_ready");
        txn(32'h0000_1FFC, TO + 1, 32'h0BAD_0BAD, 1'b0, "late_ready");

        // Saturation, then clear coinciding with a new error.
        for (int i = 0; i < 300; i++) begin
            txn(32'h8000_0000 + 32'(i * 4), 1, 32'h0, 1'b0, "saturate");
        end
        txn(32'h9000_0000, 1, 32'h0, 1'b1, "clear_and_error");
        txn(32'h0000_0020, 2, 32'h0000_0077, 1'b1, "clear_only");

        // Reset while slave 1 is being addressed.
        @(negedge clk);
        cpu_valid = 1'b1;
        cpu_addr  = 32'h0000_1000;
        s_ready   = '0;
        @(negedge clk);
        check("midrst:s_valid_c1", s_valid, 32'h2);
        @(negedge clk);
        check("midrst:s_valid_c2", s_valid, 32'h2);
        reset     = 1'b1;
        cpu_valid = 1'b0;
        @(negedge clk);
        reset  = 1'b0;
        m_err  = 1'b0;
        m_addr = '0;
        m_cnt  = 0;
        check("midrst:s_valid_c3", s_valid, 32'd0);
        check("midrst:cpu_ready", cpu_ready, 32'd0);
        check("midrst:cpu_rdata", cpu_rdata, 32'd0);
        check("midrst:bus_err", bus_err, 32'd0);
        check("midrst:err_addr", err_addr, 32'd0);
        check("midrst:err_count", err_count, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst:no_ready", cpu_ready, 32'd0);
            check("midrst:no_svalid", s_valid, 32'd0);
        end
        txn(32'h0000_1004, 2, 32'h600D_F00D, 1'b0, "post_reset");

        // Randomized accesses across both windows, unmapped space and all latencies.
        for (int i = 0; i < 80; i++) begin
            k = $urandom_range(0, 3);
            if (k == 0)      a = 32'h0000_0000 + (32'($urandom_range(0, 1023)) << 2);
            else if (k == 1) a = 32'h0000_1000 + (32'($urandom_range(0, 1023)) << 2);
            else             a = $urandom | 32'h0001_0000;
            txn(a, $urandom_range(0, TO + 2), $urandom, ($urandom_range(0, 7) == 0), "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
